// File: rtl/histo_frame_sequencer.sv
// Phase controller for the intensity-histogram pipeline: clears the bins, accumulates every pixel,
// then re-reads every pixel for encoding. It drives addresses and strobes only.
module histo_frame_sequencer #(
  parameter int NPIX = 32640,
  parameter int AW   = 15,
  parameter int BINS = 256
) (
  input  logic          clk,
  input  logic          clear_n,
  input  logic          start,
  input  logic          out_stall,
  input  logic [7:0]    pix_data,
  output logic          pix_rd,
  output logic [AW-1:0] pix_addr,
  output logic          bin_clr,
  output logic          bin_inc,
  output logic [7:0]    bin_addr,
  output logic          enc_en,
  output logic          we,
  output logic          busy,
  output logic          finallydone
);

  // state | meaning
  // IDLE  | waiting for the first start after reset
  // CLR   | zero one bin per cycle
  // ACC   | read every pixel, then one drain cycle that increments the last bin
  // EMIT  | read pixels when not stalled, then one drain cycle for the last byte
  // DONE  | frame complete, waiting for the next start
  typedef enum logic [2:0] {IDLE, CLR, ACC, EMIT, DONE} state_e;

  localparam int            CW       = AW + 1;
  localparam logic [CW-1:0] NPIX_C   = CW'(NPIX);
  localparam logic [7:0]    LAST_BIN = 8'(BINS - 1);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [AW-1:0] addr_q;
  logic [7:0]    bin_q;
  logic          inc_q, enc_q;
  logic [1:0]    rst_sync_q;
  logic          rst_n;
  logic          all_issued;
  logic          rd;

  // Reset asserts immediately but releases on a clock edge.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  assign all_issued = (cnt_q == NPIX_C);
  assign rd = !all_issued && ((state_q == ACC) || ((state_q == EMIT) && !out_stall));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      bin_q   <= '0;
      inc_q   <= 1'b0;
      enc_q   <= 1'b0;
    end else begin
      inc_q <= (state_q == ACC) && rd;
      enc_q <= (state_q == EMIT) && rd;
      if (rd) begin
        addr_q <= cnt_q[AW-1:0];
        cnt_q  <= cnt_q + CW'(1);
      end
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= CLR;
            bin_q   <= '0;
            cnt_q   <= '0;
          end
        end
        CLR: begin
          bin_q <= bin_q + 8'd1;
          if (bin_q == LAST_BIN) begin
            state_q <= ACC;
            bin_q   <= '0;
          end
        end
        ACC: begin
          if (all_issued) begin
            state_q <= EMIT;
            cnt_q   <= '0;
          end
        end
        EMIT: begin
          if (all_issued) state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The bin index for an increment is the pixel value returned by the previous read.
  assign pix_rd      = rd;
  assign pix_addr    = rd ? cnt_q[AW-1:0] : addr_q;
  assign bin_clr     = (state_q == CLR);
  assign bin_inc     = inc_q;
  assign bin_addr    = inc_q ? pix_data : bin_q;
  assign enc_en      = enc_q;
  assign we          = enc_q;
  assign busy        = (state_q == CLR) || (state_q == ACC) || (state_q == EMIT);
  assign finallydone = (state_q == DONE);

endmodule

// File: tb/tb_histo_frame_sequencer.sv
// Scoreboard bench for histo_frame_sequencer with a small pixel RAM model (NPIX=8).
module tb_histo_frame_sequencer;
  localparam int NPIX = 8;
  localparam int AW   = 3;
  localparam int BINS = 256;
  localparam int FRAME_EDGES = BINS + 2 * (NPIX + 1);

  logic          clk = 1'b0;
  logic          clear_n = 1'b0;
  logic          start = 1'b0;
  logic          out_stall = 1'b0;
  logic [7:0]    pix_data = 8'd0;
  logic          pix_rd;
  logic [AW-1:0] pix_addr;
  logic          bin_clr, bin_inc, enc_en, we, busy, finallydone;
  logic [7:0]    bin_addr;

  histo_frame_sequencer #(.NPIX(NPIX), .AW(AW), .BINS(BINS)) dut (
    .clk(clk), .clear_n(clear_n), .start(start), .out_stall(out_stall),
    .pix_data(pix_data), .pix_rd(pix_rd), .pix_addr(pix_addr),
    .bin_clr(bin_clr), .bin_inc(bin_inc), .bin_addr(bin_addr),
    .enc_en(enc_en), .we(we), .busy(busy), .finallydone(finallydone)
  );

  initial forever #5 clk = ~clk;

  logic [7:0] mem [NPIX];
  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;
  int edge_cnt = 0;
  int rd_cnt = 0;
  bit rand_stall = 1'b0;

  int exp_clr[$];
  int exp_rd[$];
  int exp_inc[$];
  int exp_we[$];
  int we_cyc[$];

  always @(posedge clk) begin
    edge_cnt++;
    if (pix_rd) pix_data <= mem[pix_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pop_check(input string name, inout int q[$], input logic [31:0] act);
    ntests++;
    if (q.size() == 0) begin
      nfail++;
      $display("FAIL %s: got unexpected %0d expected none", name, act);
    end else begin
      int e;
      e = q.pop_front();
      if (act !== e) begin
        nfail++;
        $display("FAIL %s: got %0d expected %0d", name, act, e);
      end
    end
  endtask

  // Monitor: invariants every cycle, scoreboard pops whenever a strobe is seen.
  always @(negedge clk) begin
    cyc++;
    check("onehot", 32'($countones({bin_clr, bin_inc, enc_en}) <= 1), 32'd1);
    check("we_eq_enc", 32'(we), 32'(enc_en));
    check("busy_xor_done", 32'(busy && finallydone), 32'd0);
    if (bin_clr) pop_check("clr_addr", exp_clr, 32'(bin_addr));
    if (pix_rd) begin
      rd_cnt++;
      pop_check("rd_addr", exp_rd, 32'(pix_addr));
    end
    if (bin_inc) pop_check("inc_bin", exp_inc, 32'(bin_addr));
    if (we) begin
      we_cyc.push_back(cyc);
      pop_check("we_data", exp_we, 32'(pix_data));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    if (rand_stall) out_stall = 1'($urandom_range(0, 1));
  endtask

  // Reference model: a frame is every bin cleared in order, every pixel read twice in order,
  // each pixel value incremented once and emitted once.
  task automatic start_frame(output int s_edge);
    for (int i = 0; i < BINS; i++) exp_clr.push_back(i);
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < NPIX; i++) exp_rd.push_back(i);
    for (int i = 0; i < NPIX; i++) begin
      exp_inc.push_back(int'(mem[i]));
      exp_we.push_back(int'(mem[i]));
    end
    we_cyc.delete();
    rd_cnt = 0;
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    s_edge = edge_cnt;
  endtask

  task automatic wait_done(input string name, output int e);
    int n;
    n = 0;
    while (finallydone !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    if (finallydone !== 1'b1) check({name, "_timeout"}, 32'd0, 32'd1);
    e = edge_cnt;
  endtask

  task automatic check_frame_end(input string name);
    check({name, "_clr_left"}, 32'(exp_clr.size()), 32'd0);
    check({name, "_rd_left"}, 32'(exp_rd.size()), 32'd0);
    check({name, "_inc_left"}, 32'(exp_inc.size()), 32'd0);
    check({name, "_we_left"}, 32'(exp_we.size()), 32'd0);
    check({name, "_we_count"}, 32'(we_cyc.size()), NPIX);
  endtask

  initial begin
    int s, e, n;
    for (int i = 0; i < NPIX; i++) mem[i] = 8'd0;
    #23;
    check("reset_outputs", 32'({pix_rd, pix_addr, bin_clr, bin_inc, bin_addr, enc_en, we, busy, finallydone}), 32'd0);
    @(posedge clk); #2 clear_n = 1'b1;
    repeat (3) tick();

    // Frame 1: fixed pixels, no stall
    mem[0] = 8'd3; mem[1] = 8'd3; mem[2] = 8'd3; mem[3] = 8'd0;
    mem[4] = 8'd255; mem[5] = 8'd7; mem[6] = 8'd7; mem[7] = 8'd1;
    start_frame(s);
    wait_done("f1", e);
    check("f1_latency", 32'(e - s), FRAME_EDGES);
    check_frame_end("f1");
    if (we_cyc.size() == NPIX) check("f1_we_consecutive", 32'(we_cyc[NPIX-1] - we_cyc[0]), NPIX - 1);
    repeat (5) tick();
    check("f1_done_held", 32'({finallydone, busy}), 32'b10);

    // Frame 2: random pixels, start during ACC ignored, 3-cycle stall after 2nd EMIT read
    for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom);
    start_frame(s);
    check("f2_done_dropped", 32'(finallydone), 32'd0);
    repeat (BINS + 3) tick();
    check("f2_in_acc", 32'({busy, bin_clr}), 32'b10);
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (rd_cnt < NPIX + 2 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check("f2_found_emit_rd2", 32'(rd_cnt), NPIX + 2);
    #1 out_stall = 1'b1;
    repeat (3) tick();
    out_stall = 1'b0;
    wait_done("f2", e);
    check("f2_latency", 32'(e - s), FRAME_EDGES + 3);
    check_frame_end("f2");
    if (we_cyc.size() == NPIX) begin
      check("f2_we_gap_before", 32'(we_cyc[1] - we_cyc[0]), 32'd1);
      check("f2_we_gap", 32'(we_cyc[2] - we_cyc[1]), 32'd4);
    end

    // Frame 3: random stall, reset mid-EMIT after 4 bytes
    for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom);
    rand_stall = 1'b1;
    start_frame(s);
    n = 0;
    while (we_cyc.size() < 4 && n < 3000) begin
      tick(); n++;
    end
    check("f3_reached_4we", 32'(we_cyc.size()), 32'd4);
    rand_stall = 1'b0;
    out_stall = 1'b1;
    clear_n = 1'b0;
    #1;
    check("f3_async_reset", 32'({pix_rd, pix_addr, bin_clr, bin_inc, bin_addr, enc_en, we, busy, finallydone}), 32'd0);
    exp_clr.delete(); exp_rd.delete(); exp_inc.delete(); exp_we.delete();
    repeat (3) tick();
    clear_n = 1'b1;
    repeat (20) tick();
    check("f3_no_done_after_abort", 32'({finallydone, busy}), 32'd0);

    // Frame 4: full frame after abort, random stall
    for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom);
    rand_stall = 1'b1;
    start_frame(s);
    wait_done("f4", e);
    rand_stall = 1'b0;
    check_frame_end("f4");
    check("f4_latency_min", 32'(e - s >= FRAME_EDGES), 32'd1);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
